// File: rtl/cpu_program_loader.sv
// Byte-stream command decoder that loads cpu IMEM/DMEM images and gates cpu enable.
// Optional trailing checksum per write command when LOADER_CHECKSUM_EN is defined.
module cpu_program_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        enable,
  output logic        busy,
  output logic        error,
  output logic [15:0] write_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2, CHK = 3'd3,
                            WRITE = 3'd4, RUN = 3'd5} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2,
                            WRITE = 3'd4, RUN = 3'd5} state_t;
`endif

  localparam logic [16:0] IMEM_LIM = 17'(IMEM_WORDS);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_WORDS);

  function automatic logic idx_in_range(input logic dmem, input logic [15:0] idx);
    return dmem ? ({1'b0, idx} < DMEM_LIM) : ({1'b0, idx} < IMEM_LIM);
  endfunction

  state_t      state_r, state_s;
  logic        is_dmem_r, is_dmem_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [15:0] idx_r, idx_s;
  logic [63:0] shreg_r, shreg_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_r, csum_s;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif
  logic        accept_s, commit_s, chk_ok_s, last_s;
  logic        rx_ready_r, rx_ready_s;
  logic [63:0] addr_i_r, addr_i_s, addr_d_r, addr_d_s;
  logic [31:0] wdata_i_r, wdata_i_s;
  logic [63:0] wdata_d_r, wdata_d_s;
  logic        wen_i_r, wen_i_s, wen_d_r, wen_d_s;
  logic        enable_r, enable_s, busy_r, busy_s, error_r, error_s;
  logic [15:0] wcount_r, wcount_s;

  // Next-state, datapath and next-output computation
  always_comb begin
    state_s   = state_r;
    is_dmem_s = is_dmem_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shreg_s   = shreg_r;
`ifdef LOADER_CHECKSUM_EN
    csum_s    = csum_r;
`endif
    commit_s  = 1'b0;
    chk_ok_s  = 1'b1;
    enable_s  = enable_r;
    error_s   = error_r;
    wen_i_s   = 1'b0;
    wen_d_s   = 1'b0;
    addr_i_s  = addr_i_r;
    addr_d_s  = addr_d_r;
    wdata_i_s = wdata_i_r;
    wdata_d_s = wdata_d_r;
    wcount_s  = wcount_r;
    accept_s  = rx_valid && rx_ready_r;
    last_s    = is_dmem_r ? (cnt_r == 4'd7) : (cnt_r == 4'd3);

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (rx_data)
            8'h01, 8'h02: begin
              is_dmem_s = (rx_data == 8'h02);
              cnt_s     = 4'd0;
`ifdef LOADER_CHECKSUM_EN
              csum_s    = rx_data;
`endif
              state_s   = ADDR;
            end
            8'h03: begin
              enable_s = 1'b1;
              state_s  = RUN;
            end
            8'h04:   state_s = IDLE;
            default: error_s = 1'b1;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (accept_s) begin
`ifdef LOADER_CHECKSUM_EN
          csum_s = csum_step(csum_r, rx_data);
`endif
          if (cnt_r[0]) begin
            idx_s[15:8] = rx_data;
            cnt_s       = 4'd0;
            state_s     = DATA;
          end else begin
            idx_s[7:0] = rx_data;
            cnt_s      = cnt_r + 4'd1;
          end
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (accept_s) begin
          shreg_s[{cnt_r[2:0], 3'b000} +: 8] = rx_data;
`ifdef LOADER_CHECKSUM_EN
          csum_s = csum_step(csum_r, rx_data);
`endif
          if (last_s) begin
            cnt_s = 4'd0;
`ifdef LOADER_CHECKSUM_EN
            state_s = CHK;
`else
            state_s  = WRITE;
            commit_s = 1'b1;
`endif
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept_s) begin
          chk_ok_s = (rx_data == csum_r);
          commit_s = 1'b1;
          state_s  = WRITE;
        end else begin
          state_s = CHK;
        end
      end
`endif
      WRITE: state_s = IDLE;
      RUN: begin
        if (accept_s) begin
          if (rx_data == 8'h04) begin
            enable_s = 1'b0;
            state_s  = IDLE;
          end else begin
            error_s = 1'b1;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase

    // Commit uses the fully assembled index/word; strobes go out in WRITE
    if (commit_s) begin
      if (idx_in_range(is_dmem_r, idx_s) && chk_ok_s) begin
        if (is_dmem_r) begin
          wen_d_s   = 1'b1;
          addr_d_s  = {45'd0, idx_s, 3'b000};
          wdata_d_s = shreg_s;
        end else begin
          wen_i_s   = 1'b1;
          addr_i_s  = {46'd0, idx_s, 2'b00};
          wdata_i_s = shreg_s[31:0];
        end
        wcount_s = wcount_r + 16'd1;
      end else begin
        error_s = 1'b1;
      end
    end else begin
      wcount_s = wcount_r;
    end

    rx_ready_s = (state_s != WRITE);
    busy_s     = !((state_s == IDLE) || (state_s == RUN));
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_r    <= IDLE;
      is_dmem_r  <= 1'b0;
      cnt_r      <= 4'd0;
      idx_r      <= 16'd0;
      shreg_r    <= 64'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_r     <= 8'd0;
`endif
      rx_ready_r <= 1'b1;
      addr_i_r   <= 64'd0;
      addr_d_r   <= 64'd0;
      wdata_i_r  <= 32'd0;
      wdata_d_r  <= 64'd0;
      wen_i_r    <= 1'b0;
      wen_d_r    <= 1'b0;
      enable_r   <= 1'b0;
      busy_r     <= 1'b0;
      error_r    <= 1'b0;
      wcount_r   <= 16'd0;
    end else begin
      state_r    <= state_s;
      is_dmem_r  <= is_dmem_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      shreg_r    <= shreg_s;
`ifdef LOADER_CHECKSUM_EN
      csum_r     <= csum_s;
`endif
      rx_ready_r <= rx_ready_s;
      addr_i_r   <= addr_i_s;
      addr_d_r   <= addr_d_s;
      wdata_i_r  <= wdata_i_s;
      wdata_d_r  <= wdata_d_s;
      wen_i_r    <= wen_i_s;
      wen_d_r    <= wen_d_s;
      enable_r   <= enable_s;
      busy_r     <= busy_s;
      error_r    <= error_s;
      wcount_r   <= wcount_s;
    end
  end

  assign rx_ready    = rx_ready_r;
  assign addr_ext    = addr_i_r;
  assign wen_ext     = wen_i_r;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_i_r;
  assign addr_ext_2  = addr_d_r;
  assign wen_ext_2   = wen_d_r;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = wdata_d_r;
  assign enable      = enable_r;
  assign busy        = busy_r;
  assign error       = error_r;
  assign write_count = wcount_r;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader: command-level model pushes expected writes,
// a negedge monitor pops and compares whenever a write strobe appears.
module tb_cpu_program_loader;

  localparam int IMEM_W = 512;
  localparam int DMEM_W = 1024;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic        enable, busy, error;
  logic [15:0] write_count;

  cpu_program_loader #(.IMEM_WORDS(IMEM_W), .DMEM_WORDS(DMEM_W)) dut (
    .clk(clk), .arst_n(arst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .enable(enable), .busy(busy),
    .error(error), .write_count(write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dmem;
    logic [63:0] addr;
    logic [63:0] data;
    logic [15:0] cnt;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_count = 16'd0;
  bit          exp_err = 1'b0;
  bit          exp_en = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (arst_n === 1'b1 && (wen_ext === 1'b1 || wen_ext_2 === 1'b1)) begin
      check("strobes_exclusive", {63'd0, wen_ext & wen_ext_2}, 64'd0);
      check("rx_ready_low_in_write", {63'd0, rx_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got wen_ext=%0b wen_ext_2=%0b expected no strobe", wen_ext, wen_ext_2);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_port_dmem", {63'd0, wen_ext_2}, {63'd0, mon_e.dmem});
        if (mon_e.dmem) begin
          check("addr_ext_2", addr_ext_2, mon_e.addr);
          check("wdata_ext_2", wdata_ext_2, mon_e.data);
        end else begin
          check("addr_ext", addr_ext, mon_e.addr);
          check("wdata_ext", {32'd0, wdata_ext}, mon_e.data);
        end
        check("write_count_at_strobe", {48'd0, write_count}, {48'd0, mon_e.cnt});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (rx_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got rx_ready=%0b expected 1 within 10 cycles", rx_ready);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic cmd_write(input bit dmem, input logic [15:0] idx, input logic [63:0] data, input bit bad);
    logic [7:0]  cmd, cs, b;
    logic [63:0] a;
    bit          ok;
    int          nbytes;
    wr_t         e;
    nbytes = dmem ? 8 : 4;
    cmd    = dmem ? 8'h02 : 8'h01;
    ok     = (int'(idx) < (dmem ? DMEM_W : IMEM_W)) && !(bad && CSUM_ON);
    a      = {48'd0, idx};
    a      = dmem ? (a << 3) : (a << 2);
    if (ok) begin
      exp_count = exp_count + 16'd1;
      e.dmem = dmem;
      e.addr = a;
      e.data = dmem ? data : {32'd0, data[31:0]};
      e.cnt  = exp_count;
      exp_q.push_back(e);
    end else begin
      exp_err = 1'b1;
    end
    send_byte(cmd);
    send_byte(idx[7:0]);
    send_byte(idx[15:8]);
    cs = cmd ^ idx[7:0] ^ idx[15:8];
    for (int i = 0; i < nbytes; i++) begin
      b  = data[i*8 +: 8];
      cs = cs ^ b;
      send_byte(b);
    end
    if (CSUM_ON) send_byte(bad ? (cs ^ 8'hA5) : cs);
  endtask

  task automatic check_status(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
    check({tag, "_write_count"}, {48'd0, write_count}, {48'd0, exp_count});
    check({tag, "_enable"}, {63'd0, enable}, {63'd0, exp_en});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd1);
  endtask

  task automatic apply_reset();
    arst_n   = 1'b0;
    rx_valid = 1'b0;
    exp_q.delete();
    exp_count = 16'd0;
    exp_err   = 1'b0;
    exp_en    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    check("rst_wen", {62'd0, wen_ext, wen_ext_2}, 64'd0);
    check("rst_ren", {62'd0, ren_ext, ren_ext_2}, 64'd0);
    check("rst_addr_ext", addr_ext, 64'd0);
    check("rst_addr_ext_2", addr_ext_2, 64'd0);
    check("rst_wdata_ext", {32'd0, wdata_ext}, 64'd0);
    check("rst_wdata_ext_2", wdata_ext_2, 64'd0);
    check("rst_flags", {61'd0, enable, busy, error}, 64'd0);
    check("rst_write_count", {48'd0, write_count}, 64'd0);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    bit         dm;
    arst_n   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    apply_reset();

    cmd_write(1'b0, 16'd3, 64'h0000_0000_0050_0013, 1'b0);
    check_status("imem_basic");
    check("imem_addr_hold", addr_ext, 64'h0C);
    check("imem_data_hold", {32'd0, wdata_ext}, 64'h0050_0013);
    cmd_write(1'b1, 16'd5, 64'h1122_3344_5566_7788, 1'b0);
    check_status("dmem_basic");
    check("dmem_addr_hold", addr_ext_2, 64'h28);
    cmd_write(1'b0, 16'h01FF, 64'hDEAD_BEEF, 1'b0);
    cmd_write(1'b1, 16'd1023, 64'hCAFE_F00D_1234_5678, 1'b0);
    check_status("boundary_ok");

    send_byte(8'h03);
    exp_en = 1'b1;
    check("start_enable", {63'd0, enable}, 64'd1);
    send_byte(8'h01);
    exp_err = 1'b1;
    check("run_bad_byte_error", {63'd0, error}, 64'd1);
    send_byte(8'h04);
    exp_en = 1'b0;
    check("stop_enable", {63'd0, enable}, 64'd0);
    check_status("after_run");

    cmd_write(1'b0, 16'h0200, 64'h1111_2222, 1'b0);
    check_status("imem_oob");
    cmd_write(1'b1, 16'd1024, 64'h5555_6666_7777_8888, 1'b0);
    cmd_write(1'b0, 16'd7, 64'h0000_0000_A5A5_5A5A, 1'b0);
    check_status("after_oob");

    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    check("mid_cmd_busy", {63'd0, busy}, 64'd1);
    apply_reset();
    repeat (12) @(negedge clk);
    check_status("mid_reset");

    send_byte(8'h7F);
    exp_err = 1'b1;
    check_status("unknown_byte");
    apply_reset();

    if (CSUM_ON) begin
      cmd_write(1'b0, 16'd3, 64'h0050_0013, 1'b1);
      check_status("csum_bad");
      cmd_write(1'b0, 16'd3, 64'h0050_0013, 1'b0);
      check_status("csum_good");
    end

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: begin
          dm = 1'($urandom_range(0, 1));
          cmd_write(dm, 16'($urandom_range(0, dm ? 1100 : 600)), {$urandom, $urandom},
                    1'($urandom_range(0, 4) == 0));
          if ($urandom_range(0, 2) == 0)
            cmd_write(1'b1, 16'($urandom_range(0, 1023)), {$urandom, $urandom}, 1'b0);
        end
        7: begin
          send_byte(8'h03);
          exp_en = 1'b1;
          rb = 8'($urandom_range(0, 255));
          if (rb == 8'h04) rb = 8'h05;
          send_byte(rb);
          exp_err = 1'b1;
          send_byte(8'h04);
          exp_en = 1'b0;
        end
        8: send_byte(8'h04);
        default: begin
          send_byte(8'($urandom_range(5, 255)));
          exp_err = 1'b1;
        end
      endcase
      check_status("random");
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
